// File: rtl/mem_port_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : mem_port_arbiter_if
// Description : Bus bundle between the core requesters, the arbiter and the
//               backing-memory port.
// Revision    : 1.0 - initial release
// ============================================================================
interface mem_port_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              i_req;
    logic [ADDR_W-1:0] i_addr;
    logic              i_ack;
    logic [DATA_W-1:0] i_rdata;

    logic              d_req;
    logic              d_we;
    logic [1:0]        d_size;
    logic [ADDR_W-1:0] d_addr;
    logic [DATA_W-1:0] d_wdata;
    logic              d_ack;
    logic [DATA_W-1:0] d_rdata;

    logic              mem_req;
    logic              mem_we;
    logic [1:0]        mem_size;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_ack;
    logic [DATA_W-1:0] mem_rdata;

    logic              stall;
    logic              timeout_err;

    // Arbiter side
    modport slave (
        input  i_req, i_addr, d_req, d_we, d_size, d_addr, d_wdata,
        input  mem_ack, mem_rdata,
        output i_ack, i_rdata, d_ack, d_rdata,
        output mem_req, mem_we, mem_size, mem_addr, mem_wdata,
        output stall, timeout_err
    );

    // Environment side: core requesters plus memory responder
    modport master (
        output i_req, i_addr, d_req, d_we, d_size, d_addr, d_wdata,
        output mem_ack, mem_rdata,
        input  i_ack, i_rdata, d_ack, d_rdata,
        input  mem_req, mem_we, mem_size, mem_addr, mem_wdata,
        input  stall, timeout_err
    );
endinterface
`default_nettype wire

// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : mem_port_arbiter
// Description : Shares one memory port between fetch and load/store; data
//               first with fetch anti-starvation, watchdog abort on hangs.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_port_arbiter #(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int STARVE_MAX = 4,
    parameter int TIMEOUT    = 1023
) (
    input  wire logic          CLK_CPU,
    input  wire logic          reset,
    mem_port_arbiter_if.slave  bus
);

    localparam int SC_W = $clog2(STARVE_MAX + 1);
    localparam int WD_W = $clog2(TIMEOUT + 1);

    localparam logic [SC_W-1:0] C_STARVE_MAX = SC_W'(STARVE_MAX);
    localparam logic [SC_W-1:0] C_SC_ONE     = SC_W'(1);
    localparam logic [WD_W-1:0] C_WD_LAST    = WD_W'(TIMEOUT - 1);
    localparam logic [WD_W-1:0] C_WD_ONE     = WD_W'(1);
    localparam logic [1:0]      C_SIZE_WORD  = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_BUSY_I = 2'd1,
        ST_BUSY_D = 2'd2
    } state_t;

    state_t            state_q,     state_d;
    logic [SC_W-1:0]   starve_q,    starve_d;
    logic [WD_W-1:0]   wd_q,        wd_d;
    logic              mem_req_q,   mem_req_d;
    logic              mem_we_q,    mem_we_d;
    logic [1:0]        mem_size_q,  mem_size_d;
    logic [ADDR_W-1:0] mem_addr_q,  mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic              err_q,       err_d;

    logic w_busy;
    logic w_expire;
    logic w_done;
    logic w_grant_d;

    always_ff @(posedge CLK_CPU) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            starve_q    <= '0;
            wd_q        <= '0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_size_q  <= 2'b00;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            starve_q    <= starve_d;
            wd_q        <= wd_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_size_q  <= mem_size_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            err_q       <= err_d;
        end
    end

    // A real mem_ack in the watchdog's last cycle takes precedence over abort
    assign w_busy    = (state_q != ST_IDLE);
    assign w_expire  = w_busy && !bus.mem_ack && (wd_q == C_WD_LAST);
    assign w_done    = w_busy && (bus.mem_ack || w_expire);
    assign w_grant_d = bus.d_req && (!bus.i_req || (starve_q != C_STARVE_MAX));

    always_comb begin
        state_d     = state_q;
        starve_d    = starve_q;
        wd_d        = wd_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_size_d  = mem_size_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        err_d       = err_q;

        case (state_q)
            ST_IDLE: begin
                if (w_grant_d) begin
                    state_d     = ST_BUSY_D;
                    mem_req_d   = 1'b1;
                    mem_we_d    = bus.d_we;
                    mem_size_d  = bus.d_size;
                    mem_addr_d  = bus.d_addr;
                    mem_wdata_d = bus.d_wdata;
                    wd_d        = '0;
                    if (!bus.i_req) begin
                        starve_d = '0;
                    end else if (starve_q != C_STARVE_MAX) begin
                        starve_d = starve_q + C_SC_ONE;
                    end
                end else if (bus.i_req) begin
                    state_d     = ST_BUSY_I;
                    mem_req_d   = 1'b1;
                    mem_we_d    = 1'b0;
                    mem_size_d  = C_SIZE_WORD;
                    mem_addr_d  = bus.i_addr;
                    mem_wdata_d = '0;
                    wd_d        = '0;
                    starve_d    = '0;
                end
            end
            ST_BUSY_I, ST_BUSY_D: begin
                if (w_done) begin
                    state_d   = ST_IDLE;
                    mem_req_d = 1'b0;
                    if (w_expire) begin
                        err_d = 1'b1;
                    end
                end else begin
                    wd_d = wd_q + C_WD_ONE;
                end
            end
            default: begin
                state_d   = ST_IDLE;
                mem_req_d = 1'b0;
            end
        endcase
    end

    assign bus.mem_req     = mem_req_q;
    assign bus.mem_we      = mem_we_q;
    assign bus.mem_size    = mem_size_q;
    assign bus.mem_addr    = mem_addr_q;
    assign bus.mem_wdata   = mem_wdata_q;
    assign bus.timeout_err = err_q;

    // Acks are combinational from mem_ack; an aborted transaction returns zero data
    assign bus.i_ack   = (state_q == ST_BUSY_I) && w_done;
    assign bus.d_ack   = (state_q == ST_BUSY_D) && w_done;
    assign bus.i_rdata = (bus.i_ack && bus.mem_ack) ? bus.mem_rdata : '0;
    assign bus.d_rdata = (bus.d_ack && bus.mem_ack) ? bus.mem_rdata : '0;

    assign bus.stall = (bus.i_req && !bus.i_ack) || (bus.d_req && !bus.d_ack);

endmodule
`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_port_arbiter
// Description : Randomized requesters and memory responder checked against a
//               transaction-level reference of the arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_port_arbiter;

    localparam int ADDR_W     = 32;
    localparam int DATA_W     = 32;
    localparam int STARVE_MAX = 4;
    localparam int TIMEOUT    = 8;
    localparam int N_CYCLES   = 4000;

    logic CLK_CPU = 1'b0;
    logic reset   = 1'b1;

    always #5 CLK_CPU = ~CLK_CPU;

    mem_port_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    mem_port_arbiter #(
        .ADDR_W    (ADDR_W),
        .DATA_W    (DATA_W),
        .STARVE_MAX(STARVE_MAX),
        .TIMEOUT   (TIMEOUT)
    ) u_dut (
        .CLK_CPU(CLK_CPU),
        .reset  (reset),
        .bus    (bus)
    );

    int n_cmp = 0;
    int n_err = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference state: one outstanding memory transaction at most
    bit          m_busy;
    bit          m_is_d;
    bit          m_err;
    int          m_cyc;
    int          m_lat;
    int          m_starve;
    logic [31:0] m_addr;
    logic [31:0] m_wdata;
    logic        m_we;
    logic [1:0]  m_size;
    int          n_i_grants;
    int          n_d_grants;
    int          n_timeouts;

    initial begin
        bit          ack_i_prev;
        bit          ack_d_prev;
        bit          rst_prev;
        bit          rst_pending;
        bit          do_rst;
        bit          exp_done;
        bit          exp_iack;
        bit          exp_dack;
        bit          exp_stall;
        logic [31:0] exp_rd;

        bus.i_req = 1'b0;  bus.i_addr = '0;
        bus.d_req = 1'b0;  bus.d_we = 1'b0;  bus.d_size = 2'b00;
        bus.d_addr = '0;   bus.d_wdata = '0;
        bus.mem_ack = 1'b0; bus.mem_rdata = '0;

        m_busy = 0; m_is_d = 0; m_err = 0; m_cyc = 0; m_lat = 0; m_starve = 0;
        m_addr = '0; m_wdata = '0; m_we = 1'b0; m_size = 2'b00;
        n_i_grants = 0; n_d_grants = 0; n_timeouts = 0;
        ack_i_prev = 0; ack_d_prev = 0; rst_prev = 0; rst_pending = 0;

        repeat (2) @(posedge CLK_CPU);
        @(negedge CLK_CPU);
        check_eq("rst_mem_req",   bus.mem_req,     0);
        check_eq("rst_mem_we",    bus.mem_we,      0);
        check_eq("rst_mem_size",  bus.mem_size,    0);
        check_eq("rst_mem_addr",  bus.mem_addr,    0);
        check_eq("rst_mem_wdata", bus.mem_wdata,   0);
        check_eq("rst_i_ack",     bus.i_ack,       0);
        check_eq("rst_d_ack",     bus.d_ack,       0);
        check_eq("rst_i_rdata",   bus.i_rdata,     0);
        check_eq("rst_d_rdata",   bus.d_rdata,     0);
        check_eq("rst_timeout",   bus.timeout_err, 0);

        for (int k = 0; k < N_CYCLES; k++) begin
            @(posedge CLK_CPU);
            #1;
            if (k == 1500 || k == 3000) rst_pending = 1;
            do_rst = rst_pending && m_busy && !m_is_d;
            if (do_rst) rst_pending = 0;

            // Fetch requester: hold until ack, then drop or chain a new request
            if (rst_prev) begin
                bus.i_req = 1'b0;
            end else if (ack_i_prev) begin
                if ($urandom % 2 == 0) begin
                    bus.i_req  = 1'b1;
                    bus.i_addr = $urandom;
                end else begin
                    bus.i_req = 1'b0;
                end
            end else if (!bus.i_req && ($urandom % 3 == 0)) begin
                bus.i_req  = 1'b1;
                bus.i_addr = $urandom;
            end

            // Load/store requester
            if (rst_prev) begin
                bus.d_req = 1'b0;
            end else if ((ack_d_prev && ($urandom % 2 == 0)) ||
                         (!ack_d_prev && !bus.d_req && ($urandom % 3 == 0))) begin
                bus.d_req   = 1'b1;
                bus.d_we    = 1'($urandom);
                bus.d_size  = 2'($urandom % 3);
                bus.d_addr  = $urandom;
                bus.d_wdata = $urandom;
            end else if (ack_d_prev) begin
                bus.d_req = 1'b0;
            end

            // Memory responder: ack after the latency chosen at grant, stray acks when idle
            bus.mem_rdata = $urandom;
            if (m_busy) begin
                m_cyc++;
                bus.mem_ack = (m_cyc == m_lat) && !do_rst;
            end else begin
                bus.mem_ack = ($urandom % 8 == 0);
            end
            reset = do_rst;

            @(negedge CLK_CPU);
            exp_done  = m_busy && (bus.mem_ack || m_cyc == TIMEOUT);
            exp_iack  = exp_done && !m_is_d;
            exp_dack  = exp_done && m_is_d;
            exp_rd    = bus.mem_ack ? bus.mem_rdata : 32'h0;
            exp_stall = (bus.i_req && !exp_iack) || (bus.d_req && !exp_dack);

            check_eq("mem_req",     bus.mem_req,     m_busy);
            check_eq("i_ack",       bus.i_ack,       exp_iack);
            check_eq("d_ack",       bus.d_ack,       exp_dack);
            check_eq("i_rdata",     bus.i_rdata,     exp_iack ? exp_rd : 32'h0);
            check_eq("d_rdata",     bus.d_rdata,     exp_dack ? exp_rd : 32'h0);
            check_eq("stall",       bus.stall,       exp_stall);
            check_eq("timeout_err", bus.timeout_err, m_err);
            if (m_busy) begin
                check_eq("mem_addr",  bus.mem_addr,  m_addr);
                check_eq("mem_we",    bus.mem_we,    m_we);
                check_eq("mem_size",  bus.mem_size,  m_size);
                check_eq("mem_wdata", bus.mem_wdata, m_wdata);
            end

            // Advance the reference to the next cycle
            if (do_rst) begin
                m_busy = 0; m_err = 0; m_starve = 0;
            end else if (m_busy) begin
                if (exp_done) begin
                    m_busy = 0;
                    if (!bus.mem_ack) begin
                        m_err = 1;
                        n_timeouts++;
                    end
                end
            end else if (bus.i_req || bus.d_req) begin
                if (bus.d_req && bus.i_req) begin
                    m_is_d = (m_starve != STARVE_MAX);
                    m_starve = m_is_d ? ((m_starve < STARVE_MAX) ? m_starve + 1 : STARVE_MAX) : 0;
                end else begin
                    m_is_d   = bus.d_req;
                    m_starve = 0;
                end
                if (m_is_d) begin
                    m_addr = bus.d_addr; m_we = bus.d_we; m_size = bus.d_size; m_wdata = bus.d_wdata;
                    n_d_grants++;
                end else begin
                    m_addr = bus.i_addr; m_we = 1'b0; m_size = 2'b10; m_wdata = 32'h0;
                    n_i_grants++;
                end
                m_busy = 1;
                m_cyc  = 0;
                case ($urandom % 6)
                    0:       m_lat = TIMEOUT + 1 + int'($urandom % 3);
                    1:       m_lat = TIMEOUT;
                    default: m_lat = 1 + int'($urandom % 4);
                endcase
            end

            ack_i_prev = exp_iack;
            ack_d_prev = exp_dack;
            rst_prev   = do_rst;
        end

        $display("grants: fetch=%0d data=%0d timeouts=%0d", n_i_grants, n_d_grants, n_timeouts);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
